pdm_dsm_tx: RTL
===============

# pdm_dsm_tx

PCM-to-PDM transmitter; the playback counterpart of the team's sinc3 PDM decimator. Accepts signed 16-bit PCM words through a valid/ready handshake at the output word rate. Each word is held for INT_RATE mclk1 cycles (zero-order-hold interpolation) and fed to a second-order delta-sigma modulator. The modulator drives a 1-bit PDM stream to a PDM amplifier/DAC, or to a loopback into the decimator.

## Interface
- INT_RATE, 64: mclk1 cycles per PCM sample (oversampling ratio), legal 8..1024
- DATA_W, 16: PCM word width; only 16 is supported
- mclk1 input 1: PDM bit clock; all logic on posedge
- reset input 1: asynchronous, active-high; clock mclk1
- pcm_data input 16: signed two's-complement sample
- pcm_valid input 1: pcm_data valid
- pcm_ready output 1: one-entry input buffer empty
- pdm_out output 1: PDM bit stream, registered
- sample_strobe output 1: one-cycle pulse when a new sample enters the modulator
- underrun output 1: one-cycle pulse when a sample boundary finds the buffer empty

## Operation
- Reset values: pcm_ready=1, pdm_out=0, sample_strobe=0, underrun=0. Internal state also resets: buffer empty, hold=0, cnt=0, int1=0, int2=0.
- Reset asserted mid-operation clears everything immediately and drops any buffered sample.
- Handshake: a transfer occurs on a posedge with pcm_valid && pcm_ready. On that edge buf<=pcm_data and pcm_ready goes 0 on the same edge.
- pcm_ready returns to 1 on the edge where buf moves to hold. No combinational path from pcm_valid to pcm_ready.
- The master must hold pcm_data stable while pcm_valid=1 && pcm_ready=0.
- Sample counter cnt runs 0..INT_RATE-1 and wraps to 0. A boundary is the edge where cnt==INT_RATE-1.
- At a boundary with the buffer full: hold<=buf, buffer empties, sample_strobe=1.
- At a boundary with the buffer empty: hold keeps its previous value and underrun=1.
- A transfer at an edge that is also an empty-buffer boundary is captured into buf, not hold. It reaches hold at the next boundary.
- Modulator input x = hold sign-extended to ACC_W=22 bits. Feedback fb = +32768 when pdm_out=1, -32768 when pdm_out=0.
- Each edge, the modulator updates:
  - int1_n = int1 + x - fb
  - int2_n = int2 + int1_n - fb
  - int1<=int1_n; int2<=int2_n; pdm_out<=(int2_n >= 0)
- Integrators wrap modulo 2^22 (no saturation).
- Stable input range is |x| <= 0.75 FS. Without clamping, larger inputs are unspecified but must not deadlock the handshake.
- Ones density converges to (1 + x/32768)/2.

## Timing
- pdm_out changes only on posedge mclk1, so it is stable for negedge-sampling receivers.
- Latency: a word accepted at edge T reaches hold at the first boundary after T. It affects pdm_out at the following edge.
- Sustained throughput: one word per INT_RATE cycles. The buffer allows a word to be presented anywhere within the preceding period.
- sample_strobe and underrun are mutually exclusive, and each occurs at most once per INT_RATE cycles.

## Configuration
- PDM_TX_CLAMP_EN defined: pcm_data is clamped to [-24576, 24575] before entering buf, guaranteeing modulator stability.
- PDM_TX_CLAMP_EN undefined: pcm_data passes unchanged.

## Structure
- Package pdm_tx_pkg holds:
  - ACC_W=22
  - FB_POS=32768 and FB_NEG=-32768
  - CLAMP_MAX=24575 and CLAMP_MIN=-24576
  - typedef acc_t (signed [ACC_W-1:0])
- Sub-module pdm_dsm2 holds the modulator core (hold in, pdm_out out, int1/int2 state). The top level holds the handshake buffer, sample counter and strobes.

## Test plan
- Reset: assert reset mid-stream with buffer full.
  -> All outputs return to reset values immediately; pcm_ready=1 the cycle after release.
- Zero input, INT_RATE=64: stream 0x0000 continuously for 16 words.
  -> Ones count over the last 512 cycles is 256±4; no underrun.
- Half scale: stream 16384 continuously.
  -> Ones count over 1024 cycles is 768±4. Stream -16384 -> 256±4.
- Handshake and underrun: stop pcm_valid for one sample period.
  -> Exactly one underrun pulse; hold repeats the prior value. After resuming, sample_strobe pulses at the next boundary.
  - Also present a word on a boundary edge with the buffer empty -> word enters hold one period later.
- Back-pressure: hold pcm_valid high.
  -> pcm_ready is high for exactly one cycle per 64 (plus the first transfer); no word is lost or duplicated (scoreboard compare).
- Clamp: with PDM_TX_CLAMP_EN, stream 32767.
  -> Ones count over 1024 cycles is 896±8. Without the macro, verify only that the handshake continues.

Source files
------------

// File: rtl/pdm_tx_pkg.sv
// pdm_dsm_tx shared definitions: accumulator width, feedback levels,
// clamp limits and the optional input clamp helper.
package pdm_tx_pkg;

  localparam int ACC_W     = 22;
  localparam int FB_POS    = 32768;
  localparam int FB_NEG    = -32768;
  localparam int CLAMP_MAX = 24575;
  localparam int CLAMP_MIN = -24576;

  typedef logic signed [ACC_W-1:0] acc_t;

  // Limit a PCM word to the modulator's stable input range.
  function automatic logic signed [15:0] clamp_pcm(
    input logic signed [15:0] d
  );
    logic signed [15:0] r;
    r = d;
    if (d > 16'(CLAMP_MAX)) r = 16'(CLAMP_MAX);
    if (d < $signed(16'(CLAMP_MIN))) r = 16'(CLAMP_MIN);
    return r;
  endfunction

endpackage

// File: rtl/pdm_dsm2.sv
// Second-order delta-sigma modulator core for pdm_dsm_tx.
// Integrators wrap modulo 2^ACC_W; pdm_out is registered.
module pdm_dsm2
  import pdm_tx_pkg::*;
(
  input  logic               mclk1,
  input  logic               reset,
  input  logic signed [15:0] hold,
  output logic               pdm_out
);

  acc_t int1_q;
  acc_t int1_d;
  acc_t int2_q;
  acc_t int2_d;
  acc_t x;
  acc_t fb;
  logic pdm_q;
  logic pdm_d;

  // Loop filter update and 1-bit quantiser decision.
  always_comb begin
    x      = {{(ACC_W-16){hold[15]}}, hold};
    fb     = pdm_q ? acc_t'(FB_POS) : acc_t'(FB_NEG);
    int1_d = int1_q + x - fb;
    int2_d = int2_q + int1_d - fb;
    pdm_d  = ~int2_d[ACC_W-1];
  end

  // Integrator and output state.
  always_ff @(posedge mclk1 or posedge reset) begin
    if (reset) begin
      int1_q <= '0;
      int2_q <= '0;
      pdm_q  <= 1'b0;
    end else begin
      int1_q <= int1_d;
      int2_q <= int2_d;
      pdm_q  <= pdm_d;
    end
  end

  assign pdm_out = pdm_q;

endmodule

// File: rtl/pdm_dsm_tx.sv
// PCM-to-PDM transmitter: one-word input buffer, zero-order hold,
// second-order modulator. Define PDM_TX_CLAMP_EN to clamp input words.
module pdm_dsm_tx
  import pdm_tx_pkg::*;
#(
  parameter int INT_RATE = 64,
  parameter int DATA_W   = 16
) (
  input  logic                     mclk1,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] pcm_data,
  input  logic                     pcm_valid,
  output logic                     pcm_ready,
  output logic                     pdm_out,
  output logic                     sample_strobe,
  output logic                     underrun
);

  localparam int CNT_W = $clog2(INT_RATE);

  logic [CNT_W-1:0]         cnt_q;
  logic [CNT_W-1:0]         cnt_d;
  logic                     full_q;
  logic                     full_d;
  logic signed [DATA_W-1:0] pbuf_q;
  logic signed [DATA_W-1:0] pbuf_d;
  logic signed [DATA_W-1:0] hold_q;
  logic signed [DATA_W-1:0] hold_d;
  logic                     strobe_q;
  logic                     strobe_d;
  logic                     urun_q;
  logic                     urun_d;
  logic signed [DATA_W-1:0] din;
  logic                     bnd;
  logic                     xfer;

  // Input word conditioning ahead of the buffer.
  always_comb begin
`ifdef PDM_TX_CLAMP_EN
    din = clamp_pcm(pcm_data);
`else
    din = pcm_data;
`endif
  end

  // Buffer, hold register, sample counter and strobe next-state.
  always_comb begin
    bnd      = (cnt_q == CNT_W'(INT_RATE - 1));
    xfer     = pcm_valid && !full_q;
    cnt_d    = bnd ? '0 : cnt_q + CNT_W'(1);
    full_d   = full_q;
    pbuf_d   = pbuf_q;
    hold_d   = hold_q;
    strobe_d = bnd && full_q;
    urun_d   = bnd && !full_q;
    if (xfer) begin
      pbuf_d = din;
      full_d = 1'b1;
    end
    if (bnd && full_q) begin
      hold_d = pbuf_q;
      full_d = 1'b0;
    end
  end

  // Handshake and sample-rate state.
  always_ff @(posedge mclk1 or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      full_q   <= 1'b0;
      pbuf_q   <= '0;
      hold_q   <= '0;
      strobe_q <= 1'b0;
      urun_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      pbuf_q   <= pbuf_d;
      hold_q   <= hold_d;
      strobe_q <= strobe_d;
      urun_q   <= urun_d;
    end
  end

  assign pcm_ready     = ~full_q;
  assign sample_strobe = strobe_q;
  assign underrun      = urun_q;

  pdm_dsm2 u_dsm (
    .mclk1   (mclk1),
    .reset   (reset),
    .hold    (hold_q),
    .pdm_out (pdm_out)
  );

endmodule
